// File: rtl/pds_pkg.sv
// Shared types and constants for the pair distance sequencer.
package pds_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CMP, WRITE, DONE} state_t;

    localparam int N_OPS      = 32;
    localparam int LOAD_BYTES = 64;
    localparam int N_PAIRS    = 496;
    localparam int MIN_ADDR   = 66;
    localparam int MAX_ADDR   = 68;

    typedef logic signed [15:0] word_t;
endpackage

// File: rtl/abs_dist16.sv
// Combinational |a - b| for two signed 16-bit operands.
// Zero latency; no flow control.
module abs_dist16
    import pds_pkg::*;
(
    input  word_t       i_a,
    input  word_t       i_b,
    output logic [15:0] o_dist
);
    logic signed [16:0] w_diff;

    // Differences span 17 bits, but the magnitude always fits in 16.
    always_comb begin
        w_diff = {i_a[15], i_a} - {i_b[15], i_b};
        o_dist = w_diff[16] ? 16'(~w_diff + 17'sd1) : w_diff[15:0];
    end
endmodule

// File: rtl/pair_distance_sequencer.sv
// Loads 32 signed words from data_mem, finds min/max pairwise distance, writes results back.
// 564 cycles LOAD+CMP+WRITE; done rises one edge later. start high mid-run aborts to IDLE.
module pair_distance_sequencer #(
    parameter int N         = 32,
    parameter int BASE_ADDR = 0,
    parameter int MIN_ADDR  = 66,
    parameter int MAX_ADDR  = 68,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [4:0]    min_idx_j,
    output logic [4:0]    min_idx_k,
    output logic [4:0]    max_idx_j,
    output logic [4:0]    max_idx_k
);
    import pds_pkg::*;

    state_t          r_state;
    logic            r_start_q;
    logic [5:0]      r_b;
    logic [4:0]      r_j;
    logic [4:0]      r_k;
    logic [1:0]      r_w;
    logic [15:0]     r_min;
    logic [15:0]     r_max;
    logic            r_done;
    logic [AW-1:0]   r_mem_addr;
    logic            r_wr_en;
    logic [7:0]      r_wr_data;
    logic [4:0]      r_min_j;
    logic [4:0]      r_min_k;
    logic [4:0]      r_max_j;
    logic [4:0]      r_max_k;
    word_t           r_cache [N];

    logic [15:0]     w_dist;
    logic            w_min_upd;
    logic            w_max_upd;
    logic [15:0]     w_min_next;
    logic            w_last_pair;
    logic            w_fall;
    logic            w_abort;

    abs_dist16 u_dist (
        .i_a    (r_cache[r_j]),
        .i_b    (r_cache[r_k]),
        .o_dist (w_dist)
    );

    assign w_min_upd   = (w_dist < r_min);
    assign w_max_upd   = (w_dist > r_max);
    assign w_min_next  = w_min_upd ? w_dist : r_min;
    assign w_last_pair = (r_j == 5'(N - 2)) && (r_k == 5'(N - 1));
    assign w_fall      = !start && r_start_q;
    assign w_abort     = start && (r_state == LOAD || r_state == CMP || r_state == WRITE);

    // Cache has no reset: it is fully rewritten by every LOAD before any read.
    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            if (!r_b[0]) begin
                r_cache[r_b[5:1]][15:8] <= mem_rd_data;
            end else begin
                r_cache[r_b[5:1]][7:0]  <= mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_start_q  <= 1'b1;
            r_b        <= '0;
            r_j        <= '0;
            r_k        <= 5'd1;
            r_w        <= '0;
            r_min      <= 16'hFFFF;
            r_max      <= '0;
            r_done     <= 1'b0;
            r_mem_addr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_min_j    <= '0;
            r_min_k    <= '0;
            r_max_j    <= '0;
            r_max_k    <= '0;
        end else begin
            r_start_q <= start;
            if (w_abort) begin
                r_state    <= IDLE;
                r_wr_en    <= 1'b0;
                r_wr_data  <= '0;
                r_mem_addr <= '0;
                r_done     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_b        <= '0;
                        r_j        <= '0;
                        r_k        <= 5'd1;
                        r_w        <= '0;
                        r_min      <= 16'hFFFF;
                        r_max      <= '0;
                        r_min_j    <= '0;
                        r_min_k    <= '0;
                        r_max_j    <= '0;
                        r_max_k    <= '0;
                        r_done     <= 1'b0;
                        r_wr_en    <= 1'b0;
                        r_wr_data  <= '0;
                        r_mem_addr <= '0;
                        if (w_fall) begin
                            r_state    <= LOAD;
                            r_mem_addr <= AW'(BASE_ADDR);
                        end
                    end
                    LOAD: begin
                        if (r_b == 6'(LOAD_BYTES - 1)) begin
                            r_state    <= CMP;
                            r_mem_addr <= '0;
                            r_j        <= '0;
                            r_k        <= 5'd1;
                        end else begin
                            r_b        <= r_b + 6'd1;
                            r_mem_addr <= AW'(BASE_ADDR + int'(r_b) + 1);
                        end
                    end
                    CMP: begin
                        if (w_min_upd) begin
                            r_min   <= w_dist;
                            r_min_j <= r_j;
                            r_min_k <= r_k;
                        end
                        if (w_max_upd) begin
                            r_max   <= w_dist;
                            r_max_j <= r_j;
                            r_max_k <= r_k;
                        end
                        // The final comparison's min is not registered yet, so take it from w_min_next.
                        if (w_last_pair) begin
                            r_state    <= WRITE;
                            r_w        <= '0;
                            r_wr_en    <= 1'b1;
                            r_mem_addr <= AW'(MIN_ADDR);
                            r_wr_data  <= w_min_next[15:8];
                        end else if (r_k == 5'(N - 1)) begin
                            r_j <= r_j + 5'd1;
                            r_k <= r_j + 5'd2;
                        end else begin
                            r_k <= r_k + 5'd1;
                        end
                    end
                    WRITE: begin
                        if (r_w == 2'd3) begin
                            r_state    <= DONE;
                            r_wr_en    <= 1'b0;
                            r_wr_data  <= '0;
                            r_mem_addr <= '0;
                        end else begin
                            r_w <= r_w + 2'd1;
                            case (r_w)
                                2'd0: begin
                                    r_mem_addr <= AW'(MIN_ADDR + 1);
                                    r_wr_data  <= r_min[7:0];
                                end
                                2'd1: begin
                                    r_mem_addr <= AW'(MAX_ADDR);
                                    r_wr_data  <= r_max[15:8];
                                end
                                default: begin
                                    r_mem_addr <= AW'(MAX_ADDR + 1);
                                    r_wr_data  <= r_max[7:0];
                                end
                            endcase
                        end
                    end
                    DONE: begin
                        r_done <= 1'b1;
                        if (start) begin
                            r_state <= IDLE;
                            r_done  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign done        = r_done;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_data = r_wr_data;
    assign min_idx_j   = r_min_j;
    assign min_idx_k   = r_min_k;
    assign max_idx_j   = r_max_j;
    assign max_idx_k   = r_max_k;
endmodule

// File: tb/tb_pair_distance_sequencer.sv
// Bench for pair_distance_sequencer: directed table, abort/reset corner cases, random vs model.
module tb_pair_distance_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b1;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [4:0] min_idx_j, min_idx_k, max_idx_j, max_idx_k;

    logic [7:0] mem [256];
    int         ops [32];
    int         wq [$];
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        int kind;
        int emin, eminj, emink;
        int emax, emaxj, emaxk;
    } vec_t;
    vec_t vecs [3];

    pair_distance_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .min_idx_j   (min_idx_j),
        .min_idx_k   (min_idx_k),
        .max_idx_j   (max_idx_j),
        .max_idx_k   (max_idx_k)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wq.push_back(int'(mem_addr));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic load_ops();
        logic [15:0] w;
        for (int i = 0; i < 32; i++) begin
            w = 16'(ops[i]);
            mem[2*i]   = w[15:8];
            mem[2*i+1] = w[7:0];
        end
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 32; i++) begin
            case (kind)
                0: ops[i] = 100 * i;
                1: ops[i] = (i == 0) ? -32768 : (i == 1) ? 32767 : 0;
                default: ops[i] = 5;
            endcase
        end
        load_ops();
    endtask

    // Reference: global extremes first, then the earliest pair (j, then k) that attains them.
    task automatic model(output int mn, output int mnj, output int mnk,
                         output int mx, output int mxj, output int mxk);
        int d;
        mn = 1 << 20; mx = 0;
        for (int j = 0; j < 32; j++)
            for (int k = j + 1; k < 32; k++) begin
                d = (ops[j] > ops[k]) ? ops[j] - ops[k] : ops[k] - ops[j];
                if (d < mn) mn = d;
                if (d > mx) mx = d;
            end
        mnj = -1; mnk = -1; mxj = 0; mxk = 0;
        for (int j = 0; j < 32; j++)
            for (int k = j + 1; k < 32; k++) begin
                d = (ops[j] > ops[k]) ? ops[j] - ops[k] : ops[k] - ops[j];
                if (d == mn && mnj < 0) begin mnj = j; mnk = k; end
            end
        if (mx > 0) begin
            mxj = -1;
            for (int j = 0; j < 32; j++)
                for (int k = j + 1; k < 32; k++) begin
                    d = (ops[j] > ops[k]) ? ops[j] - ops[k] : ops[k] - ops[j];
                    if (d == mx && mxj < 0) begin mxj = j; mxk = k; end
                end
        end
    endtask

    task automatic do_run(input string tag, input int emin, input int eminj, input int emink,
                          input int emax, input int emaxj, input int emaxk);
        int lat = 0;
        int nw;
        wq.delete();
        start = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 700; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        chk({tag, " latency"}, lat, 565);
        chk({tag, " min_j"}, int'(min_idx_j), eminj);
        chk({tag, " min_k"}, int'(min_idx_k), emink);
        chk({tag, " max_j"}, int'(max_idx_j), emaxj);
        chk({tag, " max_k"}, int'(max_idx_k), emaxk);
        chk({tag, " mem_min"}, int'({mem[66], mem[67]}), emin);
        chk({tag, " mem_max"}, int'({mem[68], mem[69]}), emax);
        nw = wq.size();
        chk({tag, " nwrites"}, nw, 4);
        for (int i = 0; i < nw && i < 4; i++) chk({tag, " wr_addr"}, wq[i], 66 + i);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " done_drop"}, int'(done), 0);
    endtask

    initial begin
        int mn, mnj, mnk, mx, mxj, mxk;
        int seen;

        vecs[0] = '{kind: 0, emin: 100, eminj: 0, emink: 1, emax: 3100,  emaxj: 0, emaxk: 31};
        vecs[1] = '{kind: 1, emin: 0,   eminj: 2, emink: 3, emax: 65535, emaxj: 0, emaxk: 1};
        vecs[2] = '{kind: 2, emin: 0,   eminj: 0, emink: 1, emax: 0,     emaxj: 0, emaxk: 0};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", int'(done), 0);
        chk("rst wr_en", int'(mem_wr_en), 0);
        chk("rst addr", int'(mem_addr), 0);
        chk("rst wr_data", int'(mem_wr_data), 0);
        chk("rst idx", int'({min_idx_j, min_idx_k, max_idx_j, max_idx_k}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) begin
            fill(vecs[v].kind);
            do_run($sformatf("vec%0d", v), vecs[v].emin, vecs[v].eminj, vecs[v].emink,
                   vecs[v].emax, vecs[v].emaxj, vecs[v].emaxk);
        end

        // Abort at CMP cycle 200, then a clean rerun.
        fill(0);
        for (int i = 66; i < 70; i++) mem[i] = 8'h5A;
        wq.delete();
        seen = 0;
        start = 1'b0;
        @(posedge clk);
        repeat (263) @(posedge clk);
        #1;
        start = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || mem_wr_en) seen = 1;
        end
        chk("abort no_done_wr", seen, 0);
        chk("abort nwrites", wq.size(), 0);
        chk("abort addr_idle", int'(mem_addr), 0);
        chk("abort mem_intact", int'({mem[66], mem[67], mem[68], mem[69]}), 32'h5A5A5A5A);
        do_run("after_abort", vecs[0].emin, vecs[0].eminj, vecs[0].emink,
               vecs[0].emax, vecs[0].emaxj, vecs[0].emaxk);

        // Reset during WRITE cycle 2.
        fill(1);
        for (int i = 66; i < 70; i++) mem[i] = 8'hA5;
        wq.delete();
        start = 1'b0;
        @(posedge clk);
        repeat (561) @(posedge clk);
        #1;
        chk("wr2 wr_en", int'(mem_wr_en), 1);
        chk("wr2 addr", int'(mem_addr), 67);
        rst_n = 1'b0;
        #1;
        chk("arst wr_en", int'(mem_wr_en), 0);
        chk("arst addr", int'(mem_addr), 0);
        chk("arst idx", int'({min_idx_j, min_idx_k, max_idx_j, max_idx_k}), 0);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst nwrites", wq.size(), 1);
        chk("arst mem66", int'(mem[66]), 0);
        chk("arst mem67_69", int'({mem[67], mem[68], mem[69]}), 24'hA5A5A5);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_run("after_rst", vecs[1].emin, vecs[1].eminj, vecs[1].emink,
               vecs[1].emax, vecs[1].emaxj, vecs[1].emaxk);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) ops[i] = int'($urandom_range(0, 65535)) - 32768;
            load_ops();
            model(mn, mnj, mnk, mx, mxj, mxk);
            do_run($sformatf("rand%0d", r), mn, mnj, mnk, mx, mxj, mxk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
